xoodyak_msg_blocker: RTL and testbench

//  Upstream feeder for the XOODYAK hash core. Takes the message as a byte stream with a

---
 rtl/xoodyak_msg_blocker_if.sv | 27 ++
 rtl/xoodyak_msg_blocker.sv | 162 ++++++++++++++++
 tb/tb_xoodyak_msg_blocker.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xoodyak_msg_blocker_if.sv
// Byte-stream input and absorb-block output handshakes of the Xoodyak message blocker.
// master = byte source / block sink side, slave = the blocker itself.
interface xoodyak_msg_blocker_if #(
  parameter int unsigned RATE = 16
);
  logic                    in_valid;
  logic [7:0]              in_data;
  logic                    in_last;
  logic                    in_empty;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [(RATE+1)*8-1:0]   out_block;
  logic [5:0]              out_len;
  logic                    out_first;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_block, out_len, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_block, out_len, out_first, out_last
  );
endinterface

// File: rtl/xoodyak_msg_blocker.sv
// Packs a message byte stream into RATE-byte Xoodyak absorb blocks with 0x01 padding,
// tagging each block with first/last/length for the hash core.
module xoodyak_msg_blocker #(
  parameter int unsigned RATE      = 16,
  parameter int unsigned MAX_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  xoodyak_msg_blocker_if.slave  bus,
  output logic [11:0]           msg_bytes,
  output logic                  err_ovf
);
  localparam int unsigned BlockW  = (RATE + 1) * 8;
  localparam int          RateI   = RATE;
  localparam logic [5:0]  RateLen = 6'(RATE);
  localparam logic [11:0] MaxCnt  = 12'(MAX_BYTES);

  typedef enum logic [0:0] {StFill, StEmit} state_e;

  state_e             state_q, state_d;
  logic [BlockW-1:0]  buf_q, buf_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               first_pend_q, first_pend_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [5:0]         out_len_q, out_len_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [11:0]        msg_bytes_q, msg_bytes_d;
  logic               err_ovf_q, err_ovf_d;

  logic               accept;
  logic               pad_only;
  logic               go_emit;
  logic [5:0]         emit_len;
  logic               emit_last;
  logic [5:0]         cnt_inc;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_len_d    = out_len_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    msg_bytes_d  = msg_bytes_q;
    err_ovf_d    = err_ovf_q;
    accept       = 1'b0;
    pad_only     = 1'b0;
    go_emit      = 1'b0;
    emit_len     = 6'd0;
    emit_last    = 1'b0;
    cnt_inc      = cnt_q + 6'd1;

    unique case (state_q)
      StFill: begin
        in_ready_d = 1'b1;
        accept     = bus.in_valid && in_ready_q;
        if (accept) begin
          if (bus.in_last && bus.in_empty) begin
            pad_only = 1'b1;
          end else if (msg_bytes_q == MaxCnt) begin
            // Overflowed bytes are swallowed so the source can drain; only in_last still matters.
            err_ovf_d = 1'b1;
            pad_only  = bus.in_last;
          end else begin
            for (int k = 0; k < RateI; k++) begin
              if (k == int'(cnt_q)) buf_d[8*k +: 8] = bus.in_data;
            end
            cnt_d       = cnt_inc;
            msg_bytes_d = msg_bytes_q + 12'd1;
            if (bus.in_last) begin
              for (int k = 1; k <= RateI; k++) begin
                if (k == int'(cnt_inc)) buf_d[8*k +: 8] = 8'h01;
              end
              go_emit   = 1'b1;
              emit_len  = cnt_inc;
              emit_last = 1'b1;
            end else if (cnt_inc == RateLen) begin
              go_emit  = 1'b1;
              emit_len = RateLen;
            end
          end

          if (pad_only) begin
            for (int k = 0; k < RateI; k++) begin
              if (k == int'(cnt_q)) buf_d[8*k +: 8] = 8'h01;
            end
            go_emit   = 1'b1;
            emit_len  = cnt_q;
            emit_last = 1'b1;
          end
        end

        if (go_emit) begin
          state_d     = StEmit;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_len_d   = emit_len;
          out_first_d = first_pend_q;
          out_last_d  = emit_last;
        end
      end

      StEmit: begin
        if (bus.out_ready) begin
          state_d      = StFill;
          buf_d        = '0;
          cnt_d        = 6'd0;
          in_ready_d   = 1'b1;
          out_valid_d  = 1'b0;
          first_pend_d = out_last_q;
          if (out_last_q) msg_bytes_d = 12'd0;
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StFill;
      buf_q        <= '0;
      cnt_q        <= 6'd0;
      first_pend_q <= 1'b1;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_len_q    <= 6'd0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      msg_bytes_q  <= 12'd0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_len_q    <= out_len_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      msg_bytes_q  <= msg_bytes_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  // The fill buffer doubles as the output block register.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = buf_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign msg_bytes     = msg_bytes_q;
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_xoodyak_msg_blocker.sv
// Directed bench for xoodyak_msg_blocker: message byte i carries value i[7:0]; blocks are
// collected on handshake and compared against hand-written constants and a padding model.
module tb_xoodyak_msg_blocker;
  localparam int RATE = 16;
  localparam int MAXB = 1024;
  localparam int BW   = (RATE + 1) * 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] msg_bytes;
  logic        err_ovf;

  xoodyak_msg_blocker_if #(.RATE(RATE)) bus ();

  xoodyak_msg_blocker #(.RATE(RATE), .MAX_BYTES(MAXB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .msg_bytes (msg_bytes),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Block sink: 0 = always ready, 1 = ready one cycle in three, 2 = never ready.
  int            rdy_mode = 0;
  int            cyc = 0;
  logic          rdy_next;
  bit            pend = 1'b0;
  logic [BW-1:0] held_blk;
  logic [5:0]    held_len;
  logic          held_first, held_last;
  logic [BW-1:0] q_blk[$];
  logic [5:0]    q_len[$];
  logic          q_first[$];
  logic          q_last[$];

  initial bus.out_ready = 1'b0;

  always @(negedge clk) begin
    cyc++;
    case (rdy_mode)
      0:       rdy_next = 1'b1;
      1:       rdy_next = (cyc % 3 == 0);
      default: rdy_next = 1'b0;
    endcase
    if (pend && bus.out_valid) begin
      check_val("stall_block", bus.out_block, held_blk);
      check_val("stall_len", BW'(bus.out_len), BW'(held_len));
      check_val("stall_flags", BW'({bus.out_first, bus.out_last}), BW'({held_first, held_last}));
    end
    bus.out_ready = rdy_next;
    if (bus.out_valid && rdy_next) begin
      q_blk.push_back(bus.out_block);
      q_len.push_back(bus.out_len);
      q_first.push_back(bus.out_first);
      q_last.push_back(bus.out_last);
    end
    pend       = bus.out_valid && !rdy_next;
    held_blk   = bus.out_block;
    held_len   = bus.out_len;
    held_first = bus.out_first;
    held_last  = bus.out_last;
  end

  task automatic clear_q();
    q_blk.delete();
    q_len.delete();
    q_first.delete();
    q_last.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic e);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_empty = e;
    while (!bus.in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check_val("in_ready_timeout", BW'(0), BW'(1));
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  // Message of n bytes, byte i = i[7:0], in_last on the final byte.
  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_byte(8'(i), (i == n - 1), 1'b0);
    idle();
  endtask

  function automatic int exp_nblocks(input int n);
    int d = (n > MAXB) ? MAXB : n;
    if (d > 0 && d % RATE == 0 && n <= MAXB) return d / RATE;
    return d / RATE + 1;
  endfunction

  task automatic wait_blocks(input int nb);
    int t = 0;
    while (q_blk.size() < nb && t < 8000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check_val("block_count", BW'(q_blk.size()), BW'(nb));
  endtask

  task automatic check_msg(input int n);
    int            nb = exp_nblocks(n);
    int            d  = (n > MAXB) ? MAXB : n;
    int            base, len;
    logic [BW-1:0] eb;
    wait_blocks(nb);
    for (int b = 0; b < nb && b < q_blk.size(); b++) begin
      base = b * RATE;
      len  = (d - base > RATE) ? RATE : d - base;
      eb   = '0;
      for (int k = 0; k < len; k++) eb[8*k +: 8] = 8'(base + k);
      if (b == nb - 1) eb[8*len +: 8] = 8'h01;
      check_val("blk_data", q_blk[b], eb);
      check_val("blk_len", BW'(q_len[b]), BW'(len));
      check_val("blk_first", BW'(q_first[b]), BW'(b == 0));
      check_val("blk_last", BW'(q_last[b]), BW'(b == nb - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_valid"}, BW'(bus.out_valid), '0);
    check_val({tag, "_in_ready"}, BW'(bus.in_ready), '0);
    check_val({tag, "_out_block"}, bus.out_block, '0);
    check_val({tag, "_out_len"}, BW'(bus.out_len), '0);
    check_val({tag, "_flags"}, BW'({bus.out_first, bus.out_last}), '0);
    check_val({tag, "_msg_bytes"}, BW'(msg_bytes), '0);
    check_val({tag, "_err_ovf"}, BW'(err_ovf), '0);
  endtask

  initial begin
    idle();
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // 1: 19 bytes -> one full block and a 3-byte padded tail
    clear_q();
    send_msg(19);
    wait_blocks(2);
    if (q_blk.size() == 2) begin
      check_val("t1_b0", q_blk[0], BW'(136'h00_0f0e0d0c0b0a09080706050403020100));
      check_val("t1_b0_len", BW'(q_len[0]), BW'(16));
      check_val("t1_b0_fl", BW'({q_first[0], q_last[0]}), BW'(2'b10));
      check_val("t1_b1", q_blk[1], BW'(136'h01121110));
      check_val("t1_b1_len", BW'(q_len[1]), BW'(3));
      check_val("t1_b1_fl", BW'({q_first[1], q_last[1]}), BW'(2'b01));
    end
    clear_q();

    // 2: exactly RATE bytes -> pad lands in byte RATE, no second block
    send_msg(16);
    wait_blocks(1);
    if (q_blk.size() == 1) begin
      check_val("t2_b0", q_blk[0], BW'(136'h01_0f0e0d0c0b0a09080706050403020100));
      check_val("t2_len", BW'(q_len[0]), BW'(16));
      check_val("t2_fl", BW'({q_first[0], q_last[0]}), BW'(2'b11));
    end
    clear_q();

    // 3: empty message
    send_byte(8'hAA, 1'b1, 1'b1);
    idle();
    check_val("t3_msg_bytes", BW'(msg_bytes), '0);
    wait_blocks(1);
    if (q_blk.size() == 1) begin
      check_val("t3_b0", q_blk[0], BW'(1));
      check_val("t3_len", BW'(q_len[0]), '0);
      check_val("t3_fl", BW'({q_first[0], q_last[0]}), BW'(2'b11));
    end
    clear_q();

    // 4: maximum-length message with a stalling sink
    rdy_mode = 1;
    send_msg(1024);
    check_msg(1024);
    check_val("t4_err_ovf", BW'(err_ovf), '0);
    clear_q();

    // 5: one byte past MAX_BYTES -> sticky overflow, pad-only final block
    for (int i = 0; i < 1025; i++) send_byte(8'(i), (i == 1024), 1'b0);
    idle();
    check_val("t5_msg_bytes", BW'(msg_bytes), BW'(1024));
    check_val("t5_err_ovf", BW'(err_ovf), BW'(1));
    check_msg(1025);
    check_val("t5_err_sticky", BW'(err_ovf), BW'(1));
    clear_q();
    rdy_mode = 0;

    // 6: reset with 7 bytes buffered, then during a stalled EMIT
    for (int i = 0; i < 7; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
    idle();
    check_val("t6_pre_msg_bytes", BW'(msg_bytes), BW'(7));
    resetn = 1'b0;
    #1;
    check_reset_outputs("t6_rst_fill");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rdy_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check_val("t6_stalled_valid", BW'(bus.out_valid), BW'(1));
    check_val("t6_stalled_first", BW'(bus.out_first), BW'(1));
    resetn = 1'b0;
    #1;
    check_reset_outputs("t6_rst_emit");
    @(negedge clk);
    resetn = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    clear_q();
    send_msg(3);
    check_msg(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
